// File: rtl/if_id_stage.sv
// Instruction fetch stage with program counter and IF/ID pipeline register for the RV32IM pipeline.
// Latency: the fetched word reaches ID_* one edge after the first cycle that memory is ready; zero-wait throughput is 1/cycle.
// Backpressure: STALL freezes the PC and IF/ID. IMEM_BUSYWAIT holds the PC and bubbles ID. A redirect during a busy access waits in DRAIN.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_INSTR,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC4,
  output logic [31:0] ID_INSTR,
  output logic        ID_VALID,
  output logic        FETCH_STALL
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pending_q;
  logic        imem_read_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc4_q;
  logic [31:0] id_instr_q;
  logic        id_valid_q;

  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;
  logic [31:0] drain_target;
  logic        tgt_lsb_unused;

  // Redirect targets are word aligned; the low two bits carry no meaning.
  assign target_aligned = {BRANCH_TARGET[31:2], 2'b00};
  assign tgt_lsb_unused = ^BRANCH_TARGET[1:0];
  assign pc_plus4       = pc_q + 32'd4;
  // While draining, a fresh redirect overrides the one already deferred.
  assign drain_target   = BRANCH_TAKEN ? target_aligned : pending_q;

  // Fetch control FSM, program counter and IF/ID register, all updated together.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      pending_q   <= 32'd0;
      imem_read_q <= 1'b0;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q     <= S_FETCH;
          imem_read_q <= 1'b1;
        end
        S_FETCH: begin
          if (BRANCH_TAKEN) begin
            // Flush the wrong-path instruction; ID_PC/ID_PC4 keep their last values.
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            if (IMEM_BUSYWAIT) begin
              // Keep the address stable until the in-flight access completes.
              pending_q <= target_aligned;
              state_q   <= S_DRAIN;
            end else begin
              pc_q <= target_aligned;
            end
          end else if (STALL) begin
            // Hold everything; the returned word is dropped and fetched again later.
          end else if (IMEM_BUSYWAIT) begin
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
          end else begin
            id_pc_q    <= pc_q;
            id_pc4_q   <= pc_plus4;
            id_instr_q <= IMEM_INSTR;
            id_valid_q <= 1'b1;
            pc_q       <= pc_plus4;
          end
        end
        S_DRAIN: begin
          id_instr_q <= NOP_INSTR;
          id_valid_q <= 1'b0;
          if (IMEM_BUSYWAIT) begin
            pending_q <= drain_target;
          end else begin
            // The wrong-path word completes here and is discarded.
            pc_q    <= drain_target;
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  assign IMEM_ADDR   = pc_q;
  assign IMEM_READ   = imem_read_q;
  assign ID_PC       = id_pc_q;
  assign ID_PC4      = id_pc4_q;
  assign ID_INSTR    = id_instr_q;
  assign ID_VALID    = id_valid_q;
  assign FETCH_STALL = ((state_q == S_FETCH) && IMEM_BUSYWAIT) ||
                       (state_q == S_DRAIN) || (state_q == S_BOOT);

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_instr;
  logic        imem_busywait;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        fetch_stall;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] idpc;
    logic [31:0] idpc4;
    logic [31:0] idinstr;
    logic        vld;
    logic        fs;
  } exp_t;

  exp_t exp_q[$];

  if_id_stage dut (
    .CLK           (clk),
    .RESETN        (resetn),
    .STALL         (stall),
    .BRANCH_TAKEN  (branch_taken),
    .BRANCH_TARGET (branch_target),
    .IMEM_ADDR     (imem_addr),
    .IMEM_READ     (imem_read),
    .IMEM_INSTR    (imem_instr),
    .IMEM_BUSYWAIT (imem_busywait),
    .ID_PC         (id_pc),
    .ID_PC4        (id_pc4),
    .ID_INSTR      (id_instr),
    .ID_VALID      (id_valid),
    .FETCH_STALL   (fetch_stall)
  );

  always #5 clk = ~clk;

  // Memory returns the word index of the requested address.
  assign imem_instr = {2'b00, imem_addr[31:2]};

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares the outputs visible mid-cycle against the queued expectation.
  int mon_cyc = 0;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr",   mon_cyc, imem_addr,           e.addr);
      chk("imem_read",   mon_cyc, {31'd0, imem_read},   {31'd0, e.rd});
      chk("id_pc",       mon_cyc, id_pc,               e.idpc);
      chk("id_pc4",      mon_cyc, id_pc4,              e.idpc4);
      chk("id_instr",    mon_cyc, id_instr,            e.idinstr);
      chk("id_valid",    mon_cyc, {31'd0, id_valid},    {31'd0, e.vld});
      chk("fetch_stall", mon_cyc, {31'd0, fetch_stall}, {31'd0, e.fs});
      mon_cyc++;
    end
  end

  // One cycle: apply inputs shortly after the edge and queue the outputs expected during this cycle.
  task automatic step(input logic rn, input logic st, input logic br, input logic [31:0] tgt, input logic bw,
                      input logic [31:0] addr, input logic rd, input logic [31:0] ipc, input logic [31:0] ipc4,
                      input logic [31:0] iins, input logic vld, input logic fs);
    exp_t e;
    @(posedge clk);
    #2;
    resetn        = rn;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_busywait = bw;
    e.addr = addr; e.rd = rd; e.idpc = ipc; e.idpc4 = ipc4;
    e.idinstr = iins; e.vld = vld; e.fs = fs;
    exp_q.push_back(e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; imem_busywait = 1'b0;
    repeat (2) @(posedge clk);
    //   rn st br tgt           bw  addr          rd idpc          idpc4         idinstr       vld fs
    step(0, 0, 0, 32'h0,        0,  32'h0,        0, 32'h0,        32'h0,        NOP,          0,  1); // in reset
    step(1, 0, 0, 32'h0,        0,  32'h0,        0, 32'h0,        32'h0,        NOP,          0,  1); // BOOT
    step(1, 0, 0, 32'h0,        0,  32'h0,        1, 32'h0,        32'h0,        NOP,          0,  0);
    step(1, 0, 0, 32'h0,        0,  32'h4,        1, 32'h0,        32'h4,        32'h0,        1,  0);
    step(1, 0, 0, 32'h0,        0,  32'h8,        1, 32'h4,        32'h8,        32'h1,        1,  0);
    // STALL two cycles with ID_PC=0x8
    step(1, 1, 0, 32'h0,        0,  32'hC,        1, 32'h8,        32'hC,        32'h2,        1,  0);
    step(1, 1, 0, 32'h0,        0,  32'hC,        1, 32'h8,        32'hC,        32'h2,        1,  0);
    step(1, 0, 0, 32'h0,        0,  32'hC,        1, 32'h8,        32'hC,        32'h2,        1,  0);
    // BUSYWAIT three cycles at PC=0x10
    step(1, 0, 0, 32'h0,        1,  32'h10,       1, 32'hC,        32'h10,       32'h3,        1,  1);
    step(1, 0, 0, 32'h0,        1,  32'h10,       1, 32'hC,        32'h10,       NOP,          0,  1);
    step(1, 0, 0, 32'h0,        1,  32'h10,       1, 32'hC,        32'h10,       NOP,          0,  1);
    step(1, 0, 0, 32'h0,        0,  32'h10,       1, 32'hC,        32'h10,       NOP,          0,  0);
    // Branch to 0x103 while stalled: flush wins, target aligned to 0x100
    step(1, 1, 1, 32'h103,      0,  32'h14,       1, 32'h10,       32'h14,       32'h4,        1,  0);
    step(1, 0, 0, 32'h0,        0,  32'h100,      1, 32'h10,       32'h14,       NOP,          0,  0);
    // STALL with BUSYWAIT: hold, no bubble
    step(1, 1, 0, 32'h0,        1,  32'h104,      1, 32'h100,      32'h104,      32'h40,       1,  1);
    // Branch to 0x200 during busy access -> DRAIN (STALL ignored there)
    step(1, 0, 1, 32'h200,      1,  32'h104,      1, 32'h100,      32'h104,      32'h40,       1,  1);
    step(1, 1, 0, 32'h0,        1,  32'h104,      1, 32'h100,      32'h104,      NOP,          0,  1);
    step(1, 0, 0, 32'h0,        0,  32'h104,      1, 32'h100,      32'h104,      NOP,          0,  1);
    step(1, 0, 0, 32'h0,        0,  32'h200,      1, 32'h100,      32'h104,      NOP,          0,  0);
    // Branch to top word, then wraparound
    step(1, 0, 1, 32'hFFFF_FFFF,0,  32'h204,      1, 32'h200,      32'h204,      32'h80,       1,  0);
    step(1, 0, 0, 32'h0,        0,  32'hFFFF_FFFC,1, 32'h200,      32'h204,      NOP,          0,  0);
    step(1, 0, 0, 32'h0,        0,  32'h0,        1, 32'hFFFF_FFFC,32'h0,        32'h3FFF_FFFF,1,  0);
    // Two redirects during one busy access: latest wins
    step(1, 0, 1, 32'h50,       1,  32'h4,        1, 32'h0,        32'h4,        32'h0,        1,  1);
    step(1, 0, 1, 32'h60,       1,  32'h4,        1, 32'h0,        32'h4,        NOP,          0,  1);
    step(1, 0, 0, 32'h0,        0,  32'h4,        1, 32'h0,        32'h4,        NOP,          0,  1);
    // Redirect in DRAIN on the same cycle BUSYWAIT falls
    step(1, 0, 1, 32'h70,       1,  32'h60,       1, 32'h0,        32'h4,        NOP,          0,  1);
    step(1, 0, 1, 32'h80,       0,  32'h60,       1, 32'h0,        32'h4,        NOP,          0,  1);
    step(1, 0, 0, 32'h0,        0,  32'h80,       1, 32'h0,        32'h4,        NOP,          0,  0);
    // Enter DRAIN, then reset asynchronously mid-DRAIN
    step(1, 0, 1, 32'h90,       1,  32'h84,       1, 32'h80,       32'h84,       32'h20,       1,  1);
    step(1, 0, 0, 32'h0,        1,  32'h84,       1, 32'h80,       32'h84,       NOP,          0,  1);
    step(0, 0, 0, 32'h0,        1,  32'h0,        0, 32'h0,        32'h0,        NOP,          0,  1);
    step(0, 0, 0, 32'h0,        1,  32'h0,        0, 32'h0,        32'h0,        NOP,          0,  1);
    step(1, 0, 0, 32'h0,        0,  32'h0,        0, 32'h0,        32'h0,        NOP,          0,  1);
    step(1, 0, 0, 32'h0,        0,  32'h0,        1, 32'h0,        32'h0,        NOP,          0,  0);
    step(1, 0, 0, 32'h0,        0,  32'h4,        1, 32'h0,        32'h4,        32'h0,        1,  0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage and IF/ID pipeline register of the RV32IM five-stage pipeline. Owns the program counter, drives the instruction-memory read port, tolerates multi-cycle memory latency via BUSYWAIT, and presents the fetched instruction to decode. It sits directly upstream of the hazard unit:
- its IF/ID register is frozen by the hazard unit's STALL output;
- it is flushed by taken branches/jumps resolved in EX.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) placed in IF/ID on bubble/flush

- CLK  in  1  rising-edge clock
- RESETN  in  1  asynchronous, active-low reset
- STALL  in  1  from hazard unit; freeze PC and IF/ID
- BRANCH_TAKEN  in  1  EX-stage redirect request; flushes IF/ID
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored (treated as 00)
- IMEM_ADDR  out  32  instruction memory address (= PC register)
- IMEM_READ  out  1  instruction memory read strobe
- IMEM_INSTR  in  32  instruction word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
- IMEM_BUSYWAIT  in  1  memory not ready
- ID_PC  out  32  PC of instruction in IF/ID
- ID_PC4  out  32  ID_PC+4 (mod 2^32)
- ID_INSTR  out  32  instruction in IF/ID
- ID_VALID  out  1  IF/ID holds a real instruction
- FETCH_STALL  out  1  fetch cannot deliver this cycle (combinational)

## Operation
- States: BOOT, FETCH, DRAIN. Register PENDING (32) holds a deferred redirect target.
- Reset (RESETN=0, any time incl. mid-fetch/DRAIN): state=BOOT, PC=RESET_PC, IMEM_READ=0, ID_PC=0, ID_PC4=0, ID_INSTR=NOP_INSTR, ID_VALID=0, PENDING=0.
- BOOT: next edge -> FETCH, IMEM_READ<=1; PC and IF/ID unchanged.
- FETCH, evaluated each edge. Priority: BRANCH_TAKEN > STALL > IMEM_BUSYWAIT > normal.
  - BRANCH_TAKEN, BUSYWAIT=0: PC<=target; IF/ID<=bubble (NOP_INSTR, VALID=0, ID_PC/ID_PC4 hold).
  - BRANCH_TAKEN, BUSYWAIT=1: PENDING<=target; IF/ID<=bubble; state<=DRAIN; PC holds so the in-flight access completes unchanged.
  - STALL: PC and all IF/ID outputs hold; returned IMEM_INSTR discarded and re-fetched.
  - BUSYWAIT: PC holds; IF/ID<=bubble.
  - Normal: ID_PC<=PC, ID_PC4<=PC+4, ID_INSTR<=IMEM_INSTR, ID_VALID<=1, PC<=PC+4.
- DRAIN: IF/ID held as bubble; STALL ignored.
  - BRANCH_TAKEN: PENDING<=new target (latest wins).
  - When BUSYWAIT=0: returned word discarded, PC<=PENDING (or the simultaneous new target), state<=FETCH.
- IMEM_READ=1 in FETCH and DRAIN.
- FETCH_STALL = (state==FETCH & IMEM_BUSYWAIT) | state==DRAIN | state==BOOT.
- Arithmetic: PC+4 wraps (32'hFFFF_FFFC -> 0). PC[1:0] always 00.

## Timing
- All registers update on CLK rising edge; reset is asynchronous and takes effect immediately.
- IMEM_ADDR changes only on edges; memory sees a stable address for the whole access.
- Fetch latency: instruction at PC appears on ID_* the edge after the first cycle with BUSYWAIT=0. Zero-wait throughput is one instruction per cycle.
- Taken branch in FETCH with BUSYWAIT=0: IMEM_ADDR=target one cycle later; the first target instruction reaches ID two cycles after the branch edge.
- Branch during busy access: target is issued the cycle after BUSYWAIT falls.
- STALL with BUSYWAIT=1: stall wins; IF/ID holds (no bubble inserted over a held instruction).
- Simultaneous STALL and BRANCH_TAKEN: flush wins; the older branch kills the stalled instruction.

## Test plan
- Reset release, zero-wait memory returning addr>>2: IMEM_ADDR 0,4,8,... from cycle 1. ID_INSTR 0,1,2 with ID_VALID=1 from cycle 2. ID_PC4=ID_PC+4.
- BUSYWAIT=1 for 3 cycles at PC=0x10: PC held at 0x10, ID_VALID=0/NOP_INSTR for 3 cycles, then ID_PC=0x10 with the correct word.
- STALL=1 for 2 cycles with ID_PC=0x8: ID_* and IMEM_ADDR frozen (0x8, 0xC). On release, the 0xC word enters ID exactly once, no duplication.
- BRANCH_TAKEN target 0x103 while STALL=1: IF/ID flushed to NOP/VALID=0 next edge, IMEM_ADDR=0x100, next ID_PC=0x100.
- BRANCH_TAKEN (0x200) while BUSYWAIT=1 for 2 more cycles: state DRAIN, FETCH_STALL=1, returned word never reaches ID, then IMEM_ADDR=0x200.
- PC=0xFFFF_FFFC fetched -> next IMEM_ADDR=0, ID_PC4=0. RESETN pulsed low mid-DRAIN -> all outputs immediately at reset values; restart from RESET_PC.
